calc_seq_core: RTL and testbench
================================

CALC_SEQ_CORE -- requirements
Module: calc_seq_core

Interface
REQ-001 SHALL: clk  input  1  single clock; all state on rising edge.
REQ-002 SHALL: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL: ena  input  1  high = run; low = freeze all state except strobe synchronizer.
REQ-004 SHALL: ui_in  input  8  operand A, operand B, or opcode (ui_in[2:0]), chosen by entry state.
REQ-005 SHALL: uio_in  input  8  [0] strobe (async level, enter), [1] clear (sync), [7:2] ignored.
REQ-006 SHALL: uo_out  output  8  result byte.
REQ-007 SHALL: uio_out  output  8  [3] err, [4] carry/borrow, [5] zero, [6] busy, [7] valid, [2:0] constant 0.
REQ-008 SHALL: uio_oe  output  8  constant 8'hF8.

Function
REQ-009 SHALL: pass uio_in[0] through a 2-flop synchronizer, then a rising-edge detector, giving a 1-cycle stb pulse 3 cycles after the pin rises.
REQ-010 SHALL: implement states WAIT_A, WAIT_B, WAIT_OP, EXEC, DONE.
REQ-011 SHALL: on stb in WAIT_A, latch A=ui_in and go to WAIT_B; in WAIT_B, latch B and go to WAIT_OP; in WAIT_OP, latch op=ui_in[2:0] and go to EXEC.
REQ-012 SHALL: set busy=1 exactly while in EXEC; stb in EXEC is ignored.
REQ-013 SHALL: implement ops 000 A+B, 001 A-B, 010 A&B, 011 A|B, 100 A^B, 101 A*B (low byte), 110 A<<B[2:0], 111 A>>B[2:0].
REQ-014 SHALL: complete every non-multiply op in one EXEC cycle, entering DONE on the next edge.
REQ-015 SHALL: implement multiply as a shift-add iterating over 8 bits of B: exactly 8 EXEC cycles, then DONE.
REQ-016 SHALL: set carry = add carry-out; sub borrow (A<B); mul high byte nonzero; 0 for logic and shift ops.
REQ-017 SHALL: set zero = (result==0) and err = 0 whenever a result is written.
REQ-018 SHALL: on entering DONE, update uo_out and flags together and assert valid=1; they hold until the next stb or clear.
REQ-019 SHALL: on stb in DONE, clear valid, latch A=ui_in and go to WAIT_B; uo_out and flags hold their last values.
REQ-020 SHALL: on clear=1 with ena=1, go to WAIT_A and zero uo_out and uio_out in any state, aborting EXEC.
REQ-021 SHALL: give clear priority over a simultaneous stb.
REQ-022 SHALL: drop, not queue, a stb that arrives while ena=0.

Reset
REQ-023 SHALL: on rst_n=0 asynchronously force state=WAIT_A, A=B=op=0, multiply accumulator/counter=0, synchronizer and edge flops=0, uo_out=0, uio_out=0.
REQ-024 SHALL: recover cleanly when reset is asserted mid-multiply: no valid pulse and no partial result after release.
REQ-025 SHALL: not generate a spurious stb after reset release if the strobe pin is held high (edge flop loads 0, the first synchronized 1 is an edge only after a sampled 0).

Configuration
REQ-026 SHALL: use macro CALC_MUL_EN; when defined, op 101 behaves per REQ-015.
REQ-027 SHALL: when CALC_MUL_EN is undefined, exclude the multiplier; op 101 takes one EXEC cycle, then result=0, zero=1, carry=0, err=1, valid=1.

Verification
REQ-028 SHALL: enter A=200, B=100, op=000 -> uo_out=44, carry=1, zero=0, valid=1 one cycle after EXEC.
REQ-029 SHALL: enter A=5, B=10, op=001 -> uo_out=251, carry(borrow)=1; then A=7, B=7, op=001 -> uo_out=0, zero=1, carry=0.
REQ-030 SHALL: with CALC_MUL_EN, enter 15*17 -> 255, carry=0, busy high exactly 8 cycles; 16*16 -> 0, zero=1, carry=1.
REQ-031 SHALL: enter A, B, then assert clear with a simultaneous strobe -> state WAIT_A, outputs 0; the next three strobes form a fresh, correct computation.
REQ-032 SHALL: pulse rst_n during multiply cycle 4 -> all outputs 0 and no valid after release; strobe held high through reset yields no capture.
REQ-033 SHALL: without CALC_MUL_EN, op 101 on 3*4 -> uo_out=0, err=1, zero=1, valid=1; with ena=0 strobes -> no state change.

Source files
------------

// File: rtl/calc_seq_core.sv
// Strobe-driven 8-bit calculator: A, B, opcode entry, one-cycle ALU ops and an optional shift-add multiplier.
// Optional feature: define CALC_MUL_EN to build the 8-cycle multiplier for op 101.
module calc_seq_core (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t      state_r;
  logic        sync1_r, sync2_r, prev_r, armed_r;
  logic [1:0]  fill_r;
  logic [7:0]  a_r, b_r, res_r;
  logic [2:0]  op_r;
  logic        err_r, carry_r, zero_r, busy_r, valid_r;
  logic        stb_s, clr_s, mul_last_s, alu_carry_s, alu_err_s;
  logic [7:0]  alu_res_s;
  logic        unused_s;

`ifdef CALC_MUL_EN
  logic [15:0] acc_r, acc_nxt_s;
  logic [2:0]  cnt_r;
`endif

  // Strobe synchronizer and edge detector; runs regardless of ena so frozen strobes are dropped.
  // armed_r blocks an edge until a real 0 has been sampled, so a pin held high through reset never fires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
      fill_r  <= 2'b00;
      armed_r <= 1'b0;
    end else begin
      sync1_r <= uio_in[0];
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      fill_r  <= {fill_r[0], 1'b1};
      if (fill_r[1] && !sync2_r) begin
        armed_r <= 1'b1;
      end
    end
  end

  assign stb_s    = sync2_r & ~prev_r & armed_r;
  assign clr_s    = uio_in[1];
  assign unused_s = ^uio_in[7:2];

  // Result, flags and completion condition for the current EXEC cycle.
  always_comb begin
    alu_res_s   = 8'd0;
    alu_carry_s = 1'b0;
    alu_err_s   = 1'b0;
    mul_last_s  = 1'b1;
`ifdef CALC_MUL_EN
    acc_nxt_s   = acc_r;
`endif
    case (op_r)
      3'd0: {alu_carry_s, alu_res_s} = {1'b0, a_r} + {1'b0, b_r};
      3'd1: begin
        alu_res_s   = a_r - b_r;
        alu_carry_s = (a_r < b_r);
      end
      3'd2: alu_res_s = a_r & b_r;
      3'd3: alu_res_s = a_r | b_r;
      3'd4: alu_res_s = a_r ^ b_r;
      3'd5: begin
`ifdef CALC_MUL_EN
        if (b_r[cnt_r]) begin
          acc_nxt_s = acc_r + ({8'd0, a_r} << cnt_r);
        end else begin
          acc_nxt_s = acc_r;
        end
        alu_res_s   = acc_nxt_s[7:0];
        alu_carry_s = |acc_nxt_s[15:8];
        mul_last_s  = (cnt_r == 3'd7);
`else
        alu_err_s = 1'b1;
`endif
      end
      3'd6: alu_res_s = a_r << b_r[2:0];
      3'd7: alu_res_s = a_r >> b_r[2:0];
      default: alu_res_s = 8'd0;
    endcase
  end

`ifdef CALC_MUL_EN
  // Multiply accumulator and bit counter; idle at zero outside EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= 16'd0;
      cnt_r <= 3'd0;
    end else if (ena) begin
      if (clr_s || state_r != EXEC) begin
        acc_r <= 16'd0;
        cnt_r <= 3'd0;
      end else if (op_r == 3'd5) begin
        acc_r <= acc_nxt_s;
        cnt_r <= cnt_r + 3'd1;
      end
    end
  end
`endif

  // Entry/execute sequencer with registered result and flag outputs; clear wins over strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= WAIT_A;
      a_r     <= 8'd0;
      b_r     <= 8'd0;
      op_r    <= 3'd0;
      res_r   <= 8'd0;
      err_r   <= 1'b0;
      carry_r <= 1'b0;
      zero_r  <= 1'b0;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
    end else if (ena) begin
      if (clr_s) begin
        state_r <= WAIT_A;
        res_r   <= 8'd0;
        err_r   <= 1'b0;
        carry_r <= 1'b0;
        zero_r  <= 1'b0;
        busy_r  <= 1'b0;
        valid_r <= 1'b0;
      end else begin
        case (state_r)
          WAIT_A: if (stb_s) begin
            a_r     <= ui_in;
            state_r <= WAIT_B;
          end
          WAIT_B: if (stb_s) begin
            b_r     <= ui_in;
            state_r <= WAIT_OP;
          end
          WAIT_OP: if (stb_s) begin
            op_r    <= ui_in[2:0];
            busy_r  <= 1'b1;
            state_r <= EXEC;
          end
          EXEC: if (mul_last_s) begin
            res_r   <= alu_res_s;
            carry_r <= alu_carry_s;
            err_r   <= alu_err_s;
            zero_r  <= (alu_res_s == 8'd0);
            valid_r <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= DONE;
          end
          DONE: if (stb_s) begin
            valid_r <= 1'b0;
            a_r     <= ui_in;
            state_r <= WAIT_B;
          end
          default: state_r <= WAIT_A;
        endcase
      end
    end
  end

  assign uo_out  = res_r;
  assign uio_out = {valid_r, busy_r, zero_r, carry_r, err_r, 3'b000};
  assign uio_oe  = 8'hF8;

endmodule

// File: tb/tb_calc_seq_core.sv
// Self-checking bench for calc_seq_core: arithmetic reference model plus per-cycle output compare.
module tb_calc_seq_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       pin = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] ui_in = 8'd0;
  logic [7:0] uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;

  int n_chk = 0;
  int n_pass = 0;
  int busy_cnt = 0;

  logic       chk_en = 1'b0;
  logic [7:0] exp_uo = 8'd0;
  logic       exp_err = 1'b0, exp_carry = 1'b0, exp_zero = 1'b0;
  logic       exp_busy = 1'b0, exp_valid = 1'b0;

  assign uio_in = {6'b000000, clr, pin};

  calc_seq_core dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
  endtask

  // Every-cycle compare of DUT outputs against the expected-output model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("uo_out", uo_out, exp_uo);
      check("uio_out", uio_out, {exp_valid, exp_busy, exp_zero, exp_carry, exp_err, 3'b000});
      if (uio_out[6]) busy_cnt++;
    end
  end

  // Reference arithmetic: returns {err, carry, zero, result}.
  function automatic logic [10:0] model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    logic [8:0] s;
    logic [7:0] r;
    logic c, e;
`ifdef CALC_MUL_EN
    logic [15:0] p;
`endif
    r = 8'd0; c = 1'b0; e = 1'b0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; end
      3'd1: begin r = a - b; c = (a < b); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin
`ifdef CALC_MUL_EN
        p = a * b; r = p[7:0]; c = (p > 16'd255);
`else
        e = 1'b1;
`endif
      end
      3'd6: r = a << b[2:0];
      3'd7: r = a >> b[2:0];
      default: r = 8'd0;
    endcase
    return {e, c, (r == 8'd0), r};
  endfunction

  function automatic int latency(input logic [2:0] op);
`ifdef CALC_MUL_EN
    return (op == 3'd5) ? 8 : 1;
`else
    return 1;
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic zero_expect();
    exp_uo = 8'd0; exp_err = 1'b0; exp_carry = 1'b0;
    exp_zero = 1'b0; exp_busy = 1'b0; exp_valid = 1'b0;
  endtask

  // Returns just after the edge on which the DUT acts on the strobe; pin left high.
  task automatic strobe_rise(input logic [7:0] d);
    pin = 1'b0;
    tick(2);
    ui_in = d;
    pin = 1'b1;
    tick(3);
  endtask

  task automatic calc_a(input logic [7:0] a);
    strobe_rise(a);
    exp_valid = 1'b0;
    pin = 1'b0;
  endtask

  task automatic calc_rest(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    logic [10:0] r;
    strobe_rise(b);
    pin = 1'b0;
    strobe_rise({5'd0, op});
    exp_busy = 1'b1;
    pin = 1'b0;
    tick(latency(op));
    r = model(a, b, op);
    exp_uo = r[7:0]; exp_zero = r[8]; exp_carry = r[9]; exp_err = r[10];
    exp_busy = 1'b0; exp_valid = 1'b1;
  endtask

  task automatic calc(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    calc_a(a);
    calc_rest(a, b, op);
  endtask

  logic [7:0] ta [3] = '{8'hC5, 8'h81, 8'h00};
  logic [7:0] tb [3] = '{8'h3A, 8'h07, 8'hFF};

  initial begin
    zero_expect();
    chk_en = 1'b1;
    tick(3);
    check("reset_uo", uo_out, 8'd0);
    check("reset_uio", uio_out, 8'd0);
    check("uio_oe", uio_oe, 8'hF8);
    rst_n = 1'b1;
    tick(4);

    calc(8'd200, 8'd100, 3'd0);
    check("add_res", uo_out, 8'd44);
    check("add_flags", uio_out, 8'h90);
    calc(8'd5, 8'd10, 3'd1);
    check("sub_res", uo_out, 8'd251);
    check("sub_flags", uio_out, 8'h90);
    calc(8'd7, 8'd7, 3'd1);
    check("sub_zero_res", uo_out, 8'd0);
    check("sub_zero_flags", uio_out, 8'hA0);
    calc(8'h81, 8'h07, 3'd6);
    check("shl_res", uo_out, 8'h80);
    calc(8'h81, 8'h07, 3'd7);
    check("shr_res", uo_out, 8'h01);

    for (int i = 0; i < 3; i++) begin
      for (int op = 0; op < 8; op++) begin
        calc(ta[i], tb[i], op[2:0]);
      end
    end

`ifdef CALC_MUL_EN
    busy_cnt = 0;
    calc(8'd15, 8'd17, 3'd5);
    check("mul_res", uo_out, 8'd255);
    check("mul_flags", uio_out, 8'h80);
    check("mul_busy_cycles", busy_cnt, 16'd8);
    calc(8'd16, 8'd16, 3'd5);
    check("mul_ovf_res", uo_out, 8'd0);
    check("mul_ovf_flags", uio_out, 8'hB0);
`else
    calc(8'd3, 8'd4, 3'd5);
    check("mul_off_res", uo_out, 8'd0);
    check("mul_off_flags", uio_out, 8'hA8);
`endif

    // Clear arriving on the same edge as the opcode strobe.
    calc_a(8'd50);
    strobe_rise(8'd60);
    pin = 1'b0;
    tick(2);
    ui_in = 8'd0;
    pin = 1'b1;
    tick(2);
    clr = 1'b1;
    tick(1);
    zero_expect();
    clr = 1'b0;
    pin = 1'b0;
    check("clear_uo", uo_out, 8'd0);
    check("clear_uio", uio_out, 8'd0);
    calc(8'd9, 8'd3, 3'd0);
    check("after_clear_res", uo_out, 8'd12);

    // Strobe while frozen must be dropped.
    calc_a(8'd30);
    ena = 1'b0;
    tick(2);
    pin = 1'b1;
    tick(5);
    pin = 1'b0;
    tick(3);
    ena = 1'b1;
    calc_rest(8'd30, 8'd12, 3'd1);
    check("ena_drop_res", uo_out, 8'd18);

    // Reset mid-operation with the strobe pin held high through release.
    calc_a(8'd15);
    strobe_rise(8'd17);
    pin = 1'b0;
    strobe_rise(8'd5);
    exp_busy = 1'b1;
    pin = 1'b0;
`ifdef CALC_MUL_EN
    tick(3);
`endif
    pin = 1'b1;
    rst_n = 1'b0;
    zero_expect();
    tick(3);
    rst_n = 1'b1;
    tick(10);
    check("post_reset_uo", uo_out, 8'd0);
    check("post_reset_uio", uio_out, 8'd0);
    pin = 1'b0;
    calc(8'd100, 8'd27, 3'd0);
    check("post_reset_res", uo_out, 8'd127);
    tick(2);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
